// File: rtl/rr_mux_nx1.sv
// ============================================================================
// rr_mux_nx1 : N-to-1 valid/ready channel mux, fixed-select or round-robin,
//              with a registered output stage.
// Revision   : 1.0
// ============================================================================
`default_nettype none

module rr_mux_nx1 #(
  parameter int N    = 4,
  parameter int W    = 8,
  parameter int SELW = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  input  logic           mode,
  input  logic [SELW-1:0] sel,
  output logic [W-1:0]   out_data,
  output logic [SELW-1:0] out_ch,
  output logic           out_valid,
  input  logic           out_ready
);

  localparam int              NPAD = 2 ** SELW;
  localparam logic [SELW-1:0] LAST = SELW'(N - 1);

  logic [SELW-1:0] ptr;
  logic [NPAD-1:0] valid_ext;
  logic [W-1:0]    ch_data [NPAD];
  logic            load_en;
  logic            rr_found;
  logic [SELW-1:0] rr_idx;
  logic [SELW-1:0] cur;
  logic            grant_vld;
  logic [SELW-1:0] grant;
  logic            xfer;

  // Pad requests/data to the full index space so out-of-range indices read zero.
  always_comb begin
    valid_ext        = '0;
    valid_ext[N-1:0] = in_valid;
    for (int k = 0; k < NPAD; k++) begin
      ch_data[k] = '0;
    end
    for (int k = 0; k < N; k++) begin
      ch_data[k] = in_data[k*W +: W];
    end
  end

  // Round-robin search starts just after ptr and visits ptr itself last.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    cur      = ptr;
    for (int i = 0; i < N; i++) begin
      cur = (cur == LAST) ? '0 : cur + SELW'(1);
      if (!rr_found && valid_ext[cur]) begin
        rr_found = 1'b1;
        rr_idx   = cur;
      end
    end
  end

  always_comb begin
    grant_vld = 1'b0;
    grant     = '0;
    if (mode) begin
      grant_vld = rr_found;
      grant     = rr_idx;
    end else if ((sel <= LAST) && valid_ext[sel]) begin
      grant_vld = 1'b1;
      grant     = sel;
    end
  end

  assign load_en = !out_valid || out_ready;
  assign xfer    = load_en && grant_vld && !rst;

  // Held low during reset so no upstream word is reported accepted and then lost.
  always_comb begin
    in_ready = '0;
    for (int k = 0; k < N; k++) begin
      in_ready[k] = xfer && (grant == SELW'(k));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= LAST;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= ch_data[grant];
      out_ch    <= grant;
      if (mode) begin
        ptr <= grant;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rr_mux_nx1.sv
// ============================================================================
// tb_rr_mux_nx1 : table-driven directed bench for rr_mux_nx1 (N=4, W=8).
// Revision      : 1.0
// ============================================================================
`default_nettype none

module tb_rr_mux_nx1;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic        mode;
  logic [1:0]  sel;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;
  logic        out_valid;
  logic        out_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rr_mux_nx1 #(.N(4), .W(8), .SELW(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  typedef struct {
    logic       rst;
    logic [3:0] valid;
    logic       mode;
    logic [1:0] sel;
    logic       ordy;
    logic [3:0] rdy;
    logic       ov;
    logic [7:0] od;
    logic [1:0] oc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [3:0] v, input logic m, input logic [1:0] s,
                     input logic ordy, input logic [3:0] rdy, input logic ov,
                     input logic [7:0] od, input logic [1:0] oc);
    vec_t t;
    t.rst = r; t.valid = v; t.mode = m; t.sel = s; t.ordy = ordy;
    t.rdy = rdy; t.ov = ov; t.od = od; t.oc = oc;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle: check combinational in_ready before the edge, outputs after it.
  task automatic step(input vec_t v, input string tag);
    rst       = v.rst;
    in_valid  = v.valid;
    mode      = v.mode;
    sel       = v.sel;
    out_ready = v.ordy;
    #1;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(v.rdy));
    @(posedge clk);
    #1;
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(v.ov));
    chk({tag, ".out_data"},  32'(out_data),  32'(v.od));
    chk({tag, ".out_ch"},    32'(out_ch),    32'(v.oc));
  endtask

  initial begin
    vec_t h;
    in_data   = 32'h4433_2211;
    rst       = 1'b1;
    in_valid  = 4'b1111;
    mode      = 1'b1;
    sel       = 2'd0;
    out_ready = 1'b1;

    //   rst valid    md sel ordy rdy      ov  od     oc
    // reset held two cycles with all channels requesting
    add(1, 4'b1111, 1, 0, 1, 4'b0000, 0, 8'h00, 0);
    add(1, 4'b1111, 1, 0, 1, 4'b0000, 0, 8'h00, 0);
    // first grant after release goes to channel 0
    add(0, 4'b1111, 1, 0, 1, 4'b0001, 1, 8'h11, 0);
    // fixed select stepping 0..3
    add(0, 4'b1111, 0, 0, 1, 4'b0001, 1, 8'h11, 0);
    add(0, 4'b1111, 0, 1, 1, 4'b0010, 1, 8'h22, 1);
    add(0, 4'b1111, 0, 2, 1, 4'b0100, 1, 8'h33, 2);
    add(0, 4'b1111, 0, 3, 1, 4'b1000, 1, 8'h44, 3);
    // selected channel not valid: no grant, output drains, data/ch hold
    add(0, 4'b1011, 0, 2, 1, 4'b0000, 0, 8'h44, 3);
    // reset pointer back to 3, then full-load round-robin for 8 cycles
    add(1, 4'b1111, 1, 0, 1, 4'b0000, 0, 8'h00, 0);
    for (int i = 0; i < 8; i++) begin
      add(0, 4'b1111, 1, 0, 1, 4'b0001 << (i % 4), 1, 8'h11 * ((i % 4) + 1), 2'(i % 4));
    end
    // single request on ch0 moves ptr to 0
    add(0, 4'b0001, 1, 0, 1, 4'b0001, 1, 8'h11, 0);
    // sparse with wrap: 3, 0, 3
    add(0, 4'b1001, 1, 0, 1, 4'b1000, 1, 8'h44, 3);
    add(0, 4'b1001, 1, 0, 1, 4'b0001, 1, 8'h11, 0);
    add(0, 4'b1001, 1, 0, 1, 4'b1000, 1, 8'h44, 3);
    add(0, 4'b0100, 1, 0, 1, 4'b0100, 1, 8'h33, 2);
    // idle: output drains, data/ch hold
    add(0, 4'b0000, 1, 0, 1, 4'b0000, 0, 8'h33, 2);
    // backpressure: load 0x22, stall 3 clocks, release with no bubble
    add(0, 4'b0010, 1, 0, 1, 4'b0010, 1, 8'h22, 1);
    add(0, 4'b1111, 1, 0, 0, 4'b0000, 1, 8'h22, 1);
    add(0, 4'b1111, 1, 0, 0, 4'b0000, 1, 8'h22, 1);
    add(0, 4'b1111, 1, 0, 0, 4'b0000, 1, 8'h22, 1);
    add(0, 4'b1111, 1, 0, 1, 4'b0100, 1, 8'h33, 2);

    @(negedge clk);
    foreach (vecs[i]) begin
      step(vecs[i], $sformatf("vec%0d", i));
    end

    // Mid-operation reset: load ch0, then reset while stalled.
    h.rst = 0; h.valid = 4'b0001; h.mode = 1; h.sel = 0; h.ordy = 1;
    h.rdy = 4'b0001; h.ov = 1; h.od = 8'h11; h.oc = 0;
    step(h, "mid_load");
    h.rst = 1; h.valid = 4'b1111; h.ordy = 0;
    h.rdy = 4'b0000; h.ov = 0; h.od = 8'h00; h.oc = 0;
    step(h, "mid_rst");
    // pointer back at 3 so channel 0 wins first
    h.rst = 0; h.valid = 4'b1111; h.ordy = 1;
    h.rdy = 4'b0001; h.ov = 1; h.od = 8'h11; h.oc = 0;
    step(h, "post_rst");
    h.valid = 4'b0000;
    h.rdy = 4'b0000; h.ov = 0; h.od = 8'h11; h.oc = 0;
    step(h, "post_idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
